pwm_deadband: RTL and testbench

- Downstream stage of the PWM peripheral. Consumes one channel's PWM output (o_pwm / o_pwm_2) and produces a complementary high-side/low-side gate-drive pair.
- Inserts programmable dead time on each transition and swallows pulses shorter than the dead time.
- Latches an external fault and forces both outputs to their inactive level until software clears the fault.
- Software programs it over the same simple register bus (re/we/addr/wdata/rdata) used by the PWM block.

---
 rtl/pwm_deadband.sv | 137 +++++++++++++
 tb/tb_pwm_deadband.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadband.sv
// Complementary gate-drive generator: dead-time insertion, short-pulse swallowing
// and a latched fault shutdown, all programmed over the PWM register bus.
module pwm_deadband #(
  parameter int CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        pwm_i,
  input  logic        fault_i,
  output logic        pwm_hi_o,
  output logic        pwm_lo_o,
  output logic        oe_hi_o,
  output logic        oe_lo_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEAD_R = 3'd1,
    HI_ON  = 3'd2,
    DEAD_F = 3'd3,
    LO_ON  = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rise_dly, fall_dly;
  logic               en, inv_hi, inv_lo;
  logic               fault_latched;
  logic               wr, ctrl_wr;

  assign wr      = we_i & ~re_i;
  assign ctrl_wr = wr && (addr_i == 8'h00);

  // Register file and fault latch; a fault in the clear cycle keeps the latch set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en            <= 1'b0;
      inv_hi        <= 1'b0;
      inv_lo        <= 1'b0;
      rise_dly      <= '0;
      fall_dly      <= '0;
      fault_latched <= 1'b0;
    end else begin
      if (ctrl_wr) {inv_lo, inv_hi, en} <= wdata_i[2:0];
      if (wr && addr_i == 8'h04) rise_dly <= wdata_i[CNT_W-1:0];
      if (wr && addr_i == 8'h08) fall_dly <= wdata_i[CNT_W-1:0];
      if (fault_i)                      fault_latched <= 1'b1;
      else if (ctrl_wr && wdata_i[3])   fault_latched <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fault_latched || fault_i) begin
      state_d = FAULT;
    end else if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, LO_ON: begin
          // a zero delay skips the dead state entirely
          if (pwm_i) begin
            if (rise_dly == '0) state_d = HI_ON;
            else begin
              state_d = DEAD_R;
              cnt_d   = rise_dly - CNT_W'(1);
            end
          end else if (state_q == IDLE) begin
            if (fall_dly == '0) state_d = LO_ON;
            else begin
              state_d = DEAD_F;
              cnt_d   = fall_dly - CNT_W'(1);
            end
          end
        end
        HI_ON: begin
          if (!pwm_i) begin
            if (fall_dly == '0) state_d = LO_ON;
            else begin
              state_d = DEAD_F;
              cnt_d   = fall_dly - CNT_W'(1);
            end
          end
        end
        DEAD_R: begin
          if (!pwm_i)            state_d = LO_ON;
          else if (cnt_q == '0)  state_d = HI_ON;
          else                   cnt_d   = cnt_q - CNT_W'(1);
        end
        DEAD_F: begin
          if (pwm_i)             state_d = HI_ON;
          else if (cnt_q == '0)  state_d = LO_ON;
          else                   cnt_d   = cnt_q - CNT_W'(1);
        end
        FAULT:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign pwm_hi_o = (state_q == HI_ON) ^ inv_hi;
  assign pwm_lo_o = (state_q == LO_ON) ^ inv_lo;
  assign oe_hi_o  = en;
  assign oe_lo_o  = en;

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      8'h00:   rdata_o = {29'd0, inv_lo, inv_hi, en};
      8'h04:   rdata_o = 32'(rise_dly);
      8'h08:   rdata_o = 32'(fall_dly);
      8'h0C:   rdata_o = {28'd0, state_q, fault_latched};
      default: rdata_o = '0;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

endmodule

// File: tb/tb_pwm_deadband.sv
// Directed bench for pwm_deadband: dead time, pulse swallowing, fault latch,
// inversion, live delay updates and reset.
module tb_pwm_deadband;
  logic        clk_i = 1'b0;
  logic        rst_i, re_i, we_i, pwm_i, fault_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i, rdata_o;
  logic        pwm_hi_o, pwm_lo_o, oe_hi_o, oe_lo_o;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] rd_v;

  pwm_deadband #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .re_i(re_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .pwm_i(pwm_i), .fault_i(fault_i),
    .pwm_hi_o(pwm_hi_o), .pwm_lo_o(pwm_lo_o), .oe_hi_o(oe_hi_o), .oe_lo_o(oe_lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // advance one rising edge, then settle 1ns past it
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr_i = a; wdata_i = d; we_i = 1'b1;
    tick();
    we_i = 1'b0; wdata_i = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    addr_i = a; re_i = 1'b1;
    #1;
    d = rdata_o;
    re_i = 1'b0;
  endtask

  // outputs packed as {hi, lo}
  task automatic chk_out(input string tag, input logic [1:0] exp);
    chk(tag, {30'd0, pwm_hi_o, pwm_lo_o}, {30'd0, exp});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; re_i = 0; we_i = 0; addr_i = 0; wdata_i = 0; pwm_i = 0; fault_i = 0;
    tick(); tick();
    rst_i = 0;

    // reset state
    for (int a = 0; a < 4; a++) begin
      rd(8'(a * 4), rd_v);
      chk($sformatf("rst_reg%0d", a), rd_v, 32'h0);
    end
    chk("rst_out", {28'd0, pwm_hi_o, pwm_lo_o, oe_hi_o, oe_lo_o}, 32'h0);
    wr(8'h0C, 32'hF);
    rd(8'h0C, rd_v);
    chk("status_ro", rd_v, 32'h0);

    // square wave RISE=3 FALL=2; start-up goes IDLE -> DEAD_F(2) -> LO_ON
    wr(8'h04, 3);
    wr(8'h08, 2);
    wr(8'h00, 32'h1);
    chk("oe_en", {30'd0, oe_hi_o, oe_lo_o}, 32'h3);
    tick(); chk_out("start_d1", 2'b00);
    tick(); chk_out("start_d2", 2'b00);
    tick(); chk_out("start_lo", 2'b01);
    for (int p = 0; p < 2; p++) begin
      pwm_i = 1;
      for (int t = 1; t <= 10; t++) begin
        tick();
        chk_out($sformatf("sq_hi p%0d t%0d", p, t), (t <= 3) ? 2'b00 : 2'b10);
      end
      pwm_i = 0;
      for (int t = 1; t <= 10; t++) begin
        tick();
        chk_out($sformatf("sq_lo p%0d t%0d", p, t), (t <= 2) ? 2'b00 : 2'b01);
        chk("no_overlap", {31'd0, pwm_hi_o & pwm_lo_o}, 32'h0);
      end
    end

    // 3-cycle pulse with RISE=4 is swallowed
    wr(8'h04, 4);
    pwm_i = 1;
    for (int t = 1; t <= 3; t++) begin
      tick(); chk_out($sformatf("swallow t%0d", t), 2'b00);
    end
    pwm_i = 0;
    tick(); chk_out("swallow_lo_back", 2'b01);

    // RISE=0: high side follows pwm one cycle late
    wr(8'h04, 0);
    pwm_i = 1;
    tick(); chk_out("rise0_hi", 2'b10);
    pwm_i = 0;
    tick(); chk_out("rise0_fall_d1", 2'b00);
    tick(); tick(); chk_out("rise0_lo", 2'b01);

    // fault during HI_ON
    pwm_i = 1;
    tick(); chk_out("pre_fault_hi", 2'b10);
    fault_i = 1;
    tick();
    fault_i = 0;
    chk_out("fault_off", 2'b00);
    rd(8'h0C, rd_v); chk("fault_status", rd_v, 32'hB);
    wr(8'h04, 3);
    fault_i = 1;
    wr(8'h00, 32'h9);
    fault_i = 0;
    rd(8'h0C, rd_v); chk("clr_blocked", rd_v, 32'hB);
    tick();
    rd(8'h0C, rd_v); chk("still_latched", rd_v, 32'hB);
    wr(8'h00, 32'h9);
    rd(8'h0C, rd_v); chk("cleared_fault_st", rd_v, 32'hA);
    rd(8'h00, rd_v); chk("ctrl_clr_reads0", rd_v, 32'h1);
    tick();
    rd(8'h0C, rd_v); chk("back_idle", rd_v, 32'h0);
    for (int t = 1; t <= 3; t++) begin
      tick(); chk_out($sformatf("restart_dead t%0d", t), 2'b00);
    end
    tick(); chk_out("restart_hi", 2'b10);

    // RISE 5 -> 1 written mid-count; running interval still 5 cycles
    wr(8'h04, 5);
    pwm_i = 0;
    tick(); tick(); tick(); chk_out("lo_before_upd", 2'b01);
    pwm_i = 1;
    tick(); tick();
    rd(8'h0C, rd_v); chk("in_dead_r", rd_v, 32'h2);
    wr(8'h04, 1);
    chk_out("upd_d3", 2'b00);
    tick(); chk_out("upd_d4", 2'b00);
    tick(); chk_out("upd_d5", 2'b00);
    tick(); chk_out("upd_hi", 2'b10);
    pwm_i = 0;
    tick(); tick(); tick(); chk_out("upd_lo", 2'b01);
    pwm_i = 1;
    tick(); chk_out("new_dly_d1", 2'b00);
    tick(); chk_out("new_dly_hi", 2'b10);

    // reset while in DEAD_R
    wr(8'h04, 5);
    pwm_i = 0;
    tick(); tick(); tick();
    pwm_i = 1;
    tick();
    rd(8'h0C, rd_v); chk("pre_rst_dead_r", rd_v, 32'h2);
    rst_i = 1;
    tick();
    rst_i = 0;
    chk("rst_mid_out", {28'd0, pwm_hi_o, pwm_lo_o, oe_hi_o, oe_lo_o}, 32'h0);
    rd(8'h0C, rd_v); chk("rst_mid_status", rd_v, 32'h0);
    rd(8'h04, rd_v); chk("rst_mid_rise", rd_v, 32'h0);

    // inverted outputs, FALL=0 start-up goes straight to LO_ON
    pwm_i = 0;
    wr(8'h00, 32'h6);
    chk_out("inv_idle_off", 2'b11);
    wr(8'h00, 32'h7);
    chk_out("inv_idle_en", 2'b11);
    tick(); chk_out("inv_lo_on", 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
